// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl: pipeline hazard/control unit sitting between ID and EX.
// Produces stall, flush and bubble controls for the PC, IF/ID and ID/EX
// registers. It covers three cases: load-use stalls, multi-cycle ALU ops
// frozen in EX, and return-redirect flushes. It also keeps a saturating
// count of PC stall cycles for performance debug.
module id_ex_hazard_ctrl #(
    parameter int         MUL_LAT          = 4,
    parameter int         RET_FLUSH_CYCLES = 2,
    parameter logic [1:0] LOAD_SEL         = 2'b01,
    parameter int         CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_RS_A,
    input  logic [4:0]       ID_RS_B,
    input  logic             ID_USES_B,
    input  logic [4:0]       EX_RD_ADDR,
    input  logic             EX_RF_WE,
    input  logic [1:0]       EX_RF_D_SEL,
    input  logic             EX_MUL_START,
    input  logic             EX_ret_enable,
    output logic             PC_STALL,
    output logic             IF_ID_STALL,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_BUBBLE,
    output logic             EX_HOLD,
    output logic             RET_REDIRECT,
    output logic             MUL_DONE,
    output logic [CNT_W-1:0] STALL_CNT
);

    // The length counter has to hold the longer of the two state lengths.
    localparam int MAX_LEN = (MUL_LAT > RET_FLUSH_CYCLES) ? MUL_LAT : RET_FLUSH_CYCLES;
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] RET_LOAD = CW'(RET_FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // A zero length for either sequence has no meaningful behaviour, so refuse to elaborate.
    if (MUL_LAT < 1) begin : g_bad_mul_lat
        $error("id_ex_hazard_ctrl: MUL_LAT must be >= 1");
    end
    if (RET_FLUSH_CYCLES < 1) begin : g_bad_ret_flush
        $error("id_ex_hazard_ctrl: RET_FLUSH_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MUL_WAIT  = 2'd1,
        RET_FLUSH = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          mul_done_nxt;
    logic          load_use_hz;
    logic          rs_a_match;
    logic          rs_b_match;

    // Load-use detection: the EX instruction is a load into a nonzero register that ID reads.
    always_comb begin
        rs_a_match  = (EX_RD_ADDR == ID_RS_A);
        rs_b_match  = ID_USES_B && (EX_RD_ADDR == ID_RS_B);
        load_use_hz = EX_RF_WE && (EX_RF_D_SEL == LOAD_SEL) && (EX_RD_ADDR != 5'd0)
                      && (rs_a_match || rs_b_match);
    end

    // State register, length counter and the registered MUL_DONE pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            MUL_DONE <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            MUL_DONE <= mul_done_nxt;
        end
    end

    // Next-state and Mealy outputs; everything is held low while reset is asserted.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        mul_done_nxt = 1'b0;
        PC_STALL     = 1'b0;
        IF_ID_STALL  = 1'b0;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_BUBBLE = 1'b0;
        EX_HOLD      = 1'b0;
        RET_REDIRECT = 1'b0;

        if (rst) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (EX_ret_enable) begin
                        RET_REDIRECT = 1'b1;
                        IF_ID_FLUSH  = 1'b1;
                        ID_EX_BUBBLE = 1'b1;
                        if (RET_FLUSH_CYCLES > 1) begin
                            state_nxt = RET_FLUSH;
                            cnt_nxt   = RET_LOAD;
                        end
                    end else if (EX_MUL_START) begin
                        EX_HOLD     = 1'b1;
                        PC_STALL    = 1'b1;
                        IF_ID_STALL = 1'b1;
                        if (MUL_LAT > 1) begin
                            state_nxt = MUL_WAIT;
                            cnt_nxt   = MUL_LOAD;
                        end else begin
                            mul_done_nxt = 1'b1;
                        end
                    end else if (load_use_hz) begin
                        PC_STALL     = 1'b1;
                        IF_ID_STALL  = 1'b1;
                        ID_EX_BUBBLE = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    EX_HOLD     = 1'b1;
                    PC_STALL    = 1'b1;
                    IF_ID_STALL = 1'b1;
                    if (cnt == CNT_ONE) begin
                        state_nxt    = IDLE;
                        cnt_nxt      = '0;
                        mul_done_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                RET_FLUSH: begin
                    IF_ID_FLUSH  = 1'b1;
                    ID_EX_BUBBLE = 1'b1;
                    if (cnt == CNT_ONE) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            STALL_CNT <= '0;
        end else if (PC_STALL && (STALL_CNT != {CNT_W{1'b1}})) begin
            STALL_CNT <= STALL_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// tb_id_ex_hazard_ctrl: directed vectors feed a scoreboard queue; a monitor
// on the falling edge pops each entry and compares it against both the
// default instance and a CNT_W=4 instance that share the same inputs.
module tb_id_ex_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs_a;
    logic [4:0] id_rs_b;
    logic       id_uses_b;
    logic [4:0] ex_rd_addr;
    logic       ex_rf_we;
    logic [1:0] ex_rf_d_sel;
    logic       ex_mul_start;
    logic       ex_ret_enable;

    logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, ret_redirect, mul_done;
    logic [15:0] stall_cnt;
    logic        s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_bubble, s_ex_hold, s_ret_redirect, s_mul_done;
    logic [3:0]  s_stall_cnt;

    // Output bit order: {PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_BUBBLE, EX_HOLD, RET_REDIRECT, MUL_DONE}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1101000;
    localparam logic [6:0] O_HOLD = 7'b1100100;
    localparam logic [6:0] O_RET  = 7'b0011010;
    localparam logic [6:0] O_FL   = 7'b0011000;
    localparam logic [6:0] O_DONE = 7'b0000001;

    typedef struct {
        int          idx;
        logic [6:0]  outs;
        logic [15:0] cnt;
        logic [3:0]  sat_cnt;
    } exp_t;

    exp_t sb[$];
    int   n_compared;
    int   n_mismatched;
    int   vec_idx;
    int   stall_model;

    id_ex_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .ID_RS_A(id_rs_a), .ID_RS_B(id_rs_b), .ID_USES_B(id_uses_b),
        .EX_RD_ADDR(ex_rd_addr), .EX_RF_WE(ex_rf_we), .EX_RF_D_SEL(ex_rf_d_sel),
        .EX_MUL_START(ex_mul_start), .EX_ret_enable(ex_ret_enable),
        .PC_STALL(pc_stall), .IF_ID_STALL(if_id_stall), .IF_ID_FLUSH(if_id_flush),
        .ID_EX_BUBBLE(id_ex_bubble), .EX_HOLD(ex_hold), .RET_REDIRECT(ret_redirect),
        .MUL_DONE(mul_done), .STALL_CNT(stall_cnt)
    );

    id_ex_hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .ID_RS_A(id_rs_a), .ID_RS_B(id_rs_b), .ID_USES_B(id_uses_b),
        .EX_RD_ADDR(ex_rd_addr), .EX_RF_WE(ex_rf_we), .EX_RF_D_SEL(ex_rf_d_sel),
        .EX_MUL_START(ex_mul_start), .EX_ret_enable(ex_ret_enable),
        .PC_STALL(s_pc_stall), .IF_ID_STALL(s_if_id_stall), .IF_ID_FLUSH(s_if_id_flush),
        .ID_EX_BUBBLE(s_id_ex_bubble), .EX_HOLD(s_ex_hold), .RET_REDIRECT(s_ret_redirect),
        .MUL_DONE(s_mul_done), .STALL_CNT(s_stall_cnt)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs just after the rising edge and queue its expected response.
    task automatic apply_stimulus(input logic r, input logic [4:0] ra, input logic [4:0] rb,
                                  input logic ub, input logic [4:0] rd, input logic we,
                                  input logic [1:0] dsel, input logic mul, input logic ret,
                                  input logic [6:0] exp_outs);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        id_rs_a       = ra;
        id_rs_b       = rb;
        id_uses_b     = ub;
        ex_rd_addr    = rd;
        ex_rf_we      = we;
        ex_rf_d_sel   = dsel;
        ex_mul_start  = mul;
        ex_ret_enable = ret;
        if (r) stall_model = 0;
        e.idx     = vec_idx;
        e.outs    = exp_outs;
        e.cnt     = 16'(stall_model);
        e.sat_cnt = (stall_model > 15) ? 4'd15 : 4'(stall_model);
        sb.push_back(e);
        if (!r && exp_outs[6]) stall_model++;
        vec_idx++;
    endtask

    task automatic idle_cycle(input logic [6:0] exp_outs);
        apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, exp_outs);
    endtask

    // Compare one queued expectation against the live DUT outputs.
    task automatic check_output(input exp_t e);
        logic [6:0] got;
        logic [6:0] got_s;
        got   = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, ret_redirect, mul_done};
        got_s = {s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_bubble, s_ex_hold, s_ret_redirect, s_mul_done};
        n_compared += 4;
        if (got !== e.outs) begin
            n_mismatched++;
            $display("[TB] FAIL vec%0d outs: got %b want %b", e.idx, got, e.outs);
        end
        if (stall_cnt !== e.cnt) begin
            n_mismatched++;
            $display("[TB] FAIL vec%0d stall_cnt: got %0d want %0d", e.idx, stall_cnt, e.cnt);
        end
        if (got_s !== e.outs) begin
            n_mismatched++;
            $display("[TB] FAIL vec%0d sat_outs: got %b want %b", e.idx, got_s, e.outs);
        end
        if (s_stall_cnt !== e.sat_cnt) begin
            n_mismatched++;
            $display("[TB] FAIL vec%0d sat_stall_cnt: got %0d want %0d", e.idx, s_stall_cnt, e.sat_cnt);
        end
    endtask

    // Monitor: every falling edge with a pending expectation is one observed DUT response.
    always @(negedge clk) begin
        if (sb.size() > 0) check_output(sb.pop_front());
    end

    // Directed vector sequence.
    initial begin
        int wait_cycles;
        n_compared    = 0;
        n_mismatched  = 0;
        vec_idx       = 0;
        stall_model   = 0;
        rst           = 1'b1;
        id_rs_a       = '0;
        id_rs_b       = '0;
        id_uses_b     = 1'b0;
        ex_rd_addr    = '0;
        ex_rf_we      = 1'b0;
        ex_rf_d_sel   = 2'b00;
        ex_mul_start  = 1'b0;
        ex_ret_enable = 1'b0;

        // Reset state
        apply_stimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, O_NONE);
        idle_cycle(O_NONE);

        // Load-use on RS_A, zero destination, non-load source, RS_B with/without ID_USES_B
        apply_stimulus(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, O_LU);
        idle_cycle(O_NONE);
        apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, O_NONE);
        apply_stimulus(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, O_NONE);
        apply_stimulus(1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, O_LU);
        apply_stimulus(1'b0, 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, O_NONE);

        // Multi-cycle op: four hold cycles with hz and ret ignored mid-hold, then MUL_DONE
        apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, O_HOLD);
        apply_stimulus(1'b0, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0, O_HOLD);
        apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, O_HOLD);
        idle_cycle(O_HOLD);
        idle_cycle(O_DONE);
        idle_cycle(O_NONE);

        // Return: one redirect cycle, two flush cycles, inputs ignored during the flush
        apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, O_RET);
        apply_stimulus(1'b0, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 2'b01, 1'b1, 1'b0, O_FL);
        idle_cycle(O_NONE);

        // Return, mul and hz together: return path only
        apply_stimulus(1'b0, 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 2'b01, 1'b1, 1'b1, O_RET);
        idle_cycle(O_FL);

        // Reset on the second MUL_WAIT cycle; no MUL_DONE afterwards
        apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, O_HOLD);
        idle_cycle(O_HOLD);
        apply_stimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, O_NONE);
        for (int i = 0; i < 4; i++) idle_cycle(O_NONE);

        // Hazard held for 20 cycles: the 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++)
            apply_stimulus(1'b0, 5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 2'b01, 1'b0, 1'b0, O_LU);
        idle_cycle(O_NONE);
        idle_cycle(O_NONE);

        // Drain the scoreboard within a bounded number of cycles
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        n_compared++;
        if (sb.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
